pcap_stream_arbiter: RTL and testbench
======================================

# pcap_stream_arbiter

Packet-granular round-robin arbiter that shares one AXIS sink between NUM_PORTS pcap replay sources, e.g. several AXIS-mode pcap readers feeding one DUT ingress in the simulation bench. A port is granted at a packet boundary and holds the grant until its TLAST beat is accepted. Beats are forwarded through one registered output stage, with the source index and per-port packet counters exposed for scoreboarding.

## Interface
- NUM_PORTS, 2: number of requesting AXIS sources; legal range 1..16.
- DATA_WIDTH, 512: data bus width in bits; a multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8: tkeep width.
- CNT_WIDTH, 8: width of each per-port packet counter.
- SRC_WIDTH, NUM_PORTS>1 ? $clog2(NUM_PORTS) : 1: width of m_src.

Ports:
- clk_out  in  1  single clock for the block.
- reset_n  in  1  asynchronous, active-low reset.
- s_valid  in  NUM_PORTS  per-port valid.
- s_ready  out  NUM_PORTS  per-port ready.
- s_data  in  NUM_PORTS*DATA_WIDTH  port p occupies [p*DATA_WIDTH +: DATA_WIDTH].
- s_keep  in  NUM_PORTS*KEEP_WIDTH  per-port tkeep, same packing as s_data.
- s_last  in  NUM_PORTS  per-port tlast.
- m_valid  out  1  output valid.
- m_ready  in  1  output ready.
- m_data  out  DATA_WIDTH  output data.
- m_keep  out  KEEP_WIDTH  output tkeep, passed through unmodified.
- m_last  out  1  output tlast.
- m_src  out  SRC_WIDTH  index of the port that produced the current m_* beat.
- pkt_cnt  out  NUM_PORTS*CNT_WIDTH  completed packets per port, modulo 2^CNT_WIDTH.
- busy  out  1  high while state is LOCK.

## Operation
- State machine with two states, IDLE and LOCK. Registered state: grant index g, round-robin pointer rr.
- IDLE:
  - s_ready is all zero.
  - If any s_valid is high, select the first valid port scanning rr, rr+1, … modulo NUM_PORTS. Register that port as g and go to LOCK.
  - Otherwise stay in IDLE.
- LOCK:
  - s_ready[g] = !m_valid || m_ready. All other s_ready bits are 0.
  - Accept condition: s_valid[g] && s_ready[g]. On accept, the output register loads s_data/s_keep/s_last of port g, m_src <= g, m_valid <= 1.
  - If the accepted beat has s_last[g]=1: pkt_cnt[g] increments (wraps at 2^CNT_WIDTH), rr <= (g+1) mod NUM_PORTS, state goes to IDLE.
  - If s_valid[g] drops mid-packet, the block waits in LOCK indefinitely. There is no timeout.
- Output register:
  - When m_valid && m_ready and no new beat is accepted, m_valid clears.
  - While m_valid && !m_ready, all m_* outputs are held stable.
- Simultaneous requests are served strictly round-robin by packet. A lone requester is re-granted after each packet, with one IDLE cycle in between.
- NUM_PORTS=1: rr and g are always 0 and m_src is always 0.
- Reset (asynchronous, any state):
  - state=IDLE, g=0, rr=0, every pkt_cnt=0.
  - m_valid=0, m_data=0, m_keep=0, m_last=0, m_src=0, busy=0, s_ready=0.
  - A packet in flight is truncated and no m_last is emitted for it. Recovery is the downstream's responsibility.

## Timing
- Grant: port p raises s_valid before edge E0 while in IDLE. g=p and busy=1 are registered at E0, and s_ready[p] is high during the next cycle.
- First beat: accepted at E1, m_valid=1 after E1. Latency from grant decision to first output beat is 2 edges.
- Throughput: a packet of B beats occupies B+1 cycles with m_ready held at 1, i.e. one IDLE bubble per packet.
- s_ready depends combinationally on m_valid and m_ready only, never on s_valid.
- pkt_cnt and rr update on the same edge that accepts the last beat. busy falls on that edge.

## Test plan
- Single port, NUM_PORTS=2, DATA_WIDTH=64: port0 sends a 3-beat packet with m_ready=1 -> m_valid pulses for 3 consecutive cycles; m_keep on the last beat equals the input (e.g. 8'h0F); m_last is on beat 3; m_src=0; pkt_cnt[0]=1; busy is low 1 cycle after the last accept.
- Contention: both ports continuously offer 2-beat packets -> output packet order is 0,1,0,1; beats are never interleaved within a packet; after 4 packets pkt_cnt = {2,2}.
- Backpressure: m_ready=0 for 5 cycles mid-packet -> m_data/m_keep/m_last/m_src are unchanged during the stall; s_ready[g]=0; no beat is lost or duplicated (scoreboard compare).
- Source stall: port1 drops s_valid for 4 cycles mid-packet while port0 is valid -> grant stays on port1; port0 s_ready stays 0; port1's packet completes before port0 is granted.
- Counter wrap: port0 sends 256 single-beat packets with CNT_WIDTH=8 -> pkt_cnt[0] reads 0 after the 256th; every m_last is 1.
- Async reset mid-packet: assert reset_n=0 between clock edges during beat 2 -> all outputs and counters are 0 immediately; after release, a fresh packet from port1 is granted first (rr=0, only port1 valid) and delivered intact.

Source files
------------

// File: rtl/pcap_stream_arbiter.sv
`timescale 1ns / 1ps
// pcap_stream_arbiter
//
// Packet-granular round-robin arbiter sharing one AXIS sink between NUM_PORTS
// pcap replay sources. A port is granted only at a packet boundary. It keeps
// the grant until its TLAST beat has been accepted. Every beat passes through
// a single registered output stage. The stage also reports which source
// produced the beat and keeps a count of completed packets for each port.
//
// Ports:
//   clk_out  - block clock
//   reset_n  - asynchronous active-low reset
//   s_valid  - per-port tvalid
//   s_ready  - per-port tready (only the granted port can be ready)
//   s_data   - per-port tdata, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   s_keep   - per-port tkeep, same packing as s_data
//   s_last   - per-port tlast
//   m_valid  - output tvalid
//   m_ready  - output tready
//   m_data   - output tdata
//   m_keep   - output tkeep, passed through unmodified
//   m_last   - output tlast
//   m_src    - index of the port that produced the current output beat
//   pkt_cnt  - completed packets per port (wrapping), port p at [p*CNT_WIDTH +: CNT_WIDTH]
//   busy     - high while a port holds the grant
module pcap_stream_arbiter #(
   parameter int unsigned NUM_PORTS  = 2,
   parameter int unsigned DATA_WIDTH = 512,
   parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned CNT_WIDTH  = 8,
   parameter int unsigned SRC_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                            clk_out,
   input  logic                            reset_n,
   input  logic [NUM_PORTS-1:0]            s_valid,
   output logic [NUM_PORTS-1:0]            s_ready,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
   input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_keep,
   input  logic [NUM_PORTS-1:0]            s_last,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [DATA_WIDTH-1:0]           m_data,
   output logic [KEEP_WIDTH-1:0]           m_keep,
   output logic                            m_last,
   output logic [SRC_WIDTH-1:0]            m_src,
   output logic [NUM_PORTS*CNT_WIDTH-1:0]  pkt_cnt,
   output logic                            busy
);

   typedef enum logic [0:0] {StIdle, StLock} state_e;

   state_e                 state_q, state_d;
   logic [SRC_WIDTH-1:0]   g_q, g_d;
   logic [SRC_WIDTH-1:0]   rr_q, rr_d;
   logic [CNT_WIDTH-1:0]   cnt_q [NUM_PORTS];

   logic                   out_valid_q;
   logic [DATA_WIDTH-1:0]  out_data_q;
   logic [KEEP_WIDTH-1:0]  out_keep_q;
   logic                   out_last_q;
   logic [SRC_WIDTH-1:0]   out_src_q;

   logic                   out_free;
   logic                   accept;
   logic                   sel_valid;
   logic                   sel_last;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic [KEEP_WIDTH-1:0]  sel_keep;
   logic [2*NUM_PORTS-1:0] req_dbl;
   logic [NUM_PORTS-1:0]   req_rot;
   logic                   pick_found;
   logic [SRC_WIDTH-1:0]   pick_idx;

   // The output stage can take a new beat when it is empty or is being drained.
   assign out_free = !out_valid_q || m_ready;
   assign accept   = (state_q == StLock) && sel_valid && out_free;

   // Mux of the granted port's beat
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      sel_keep  = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         if (g_q == SRC_WIDTH'(p)) begin
            sel_valid = s_valid[p];
            sel_last  = s_last[p];
            sel_data  = s_data[p*DATA_WIDTH +: DATA_WIDTH];
            sel_keep  = s_keep[p*KEEP_WIDTH +: KEEP_WIDTH];
         end
      end
   end

   // Rotate the request vector so that bit 0 is the port at rr. The lowest
   // set bit of the rotated vector is then the next port in round-robin order.
   always_comb begin
      req_dbl    = {s_valid, s_valid} >> rr_q;
      req_rot    = req_dbl[NUM_PORTS-1:0];
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int unsigned j = 0; j < NUM_PORTS; j++) begin
         if (!pick_found && req_rot[j]) begin
            pick_found = 1'b1;
            pick_idx   = SRC_WIDTH'((32'(rr_q) + j) % NUM_PORTS);
         end
      end
   end

   // Next-state logic for the grant
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      rr_d    = rr_q;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               g_d     = pick_idx;
               state_d = StLock;
            end
         end
         StLock: begin
            if (accept && sel_last) begin
               state_d = StIdle;
               rr_d    = SRC_WIDTH'((32'(g_q) + 32'd1) % NUM_PORTS);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_out or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         g_q     <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         rr_q    <= rr_d;
      end
   end

   // Per-port packet counters, incremented when a TLAST beat is accepted
   always_ff @(posedge clk_out or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            cnt_q[p] <= '0;
         end
      end else if (accept && sel_last) begin
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (g_q == SRC_WIDTH'(p)) begin
               cnt_q[p] <= cnt_q[p] + CNT_WIDTH'(1);
            end
         end
      end
   end

   // Output register. Its contents stay unchanged while it is stalled, because
   // accept is false whenever out_valid_q is high and m_ready is low.
   always_ff @(posedge clk_out or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         out_src_q   <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_data_q  <= sel_data;
         out_keep_q  <= sel_keep;
         out_last_q  <= sel_last;
         out_src_q   <= g_q;
      end else if (m_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // s_ready depends only on the grant and the output stage, never on s_valid.
   always_comb begin
      s_ready = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         s_ready[p] = (state_q == StLock) && (g_q == SRC_WIDTH'(p)) && out_free;
      end
   end

   always_comb begin
      pkt_cnt = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
         pkt_cnt[p*CNT_WIDTH +: CNT_WIDTH] = cnt_q[p];
      end
   end

   assign m_valid = out_valid_q;
   assign m_data  = out_data_q;
   assign m_keep  = out_keep_q;
   assign m_last  = out_last_q;
   assign m_src   = out_src_q;
   assign busy    = (state_q == StLock);

endmodule

// File: tb/tb_pcap_stream_arbiter.sv
`timescale 1ns / 1ps
// Testbench for pcap_stream_arbiter. The stimulus process issues each packet
// into a per-port source queue and also into a per-port expected queue. The
// monitor pops one entry per output beat and compares it with the DUT output.
// The expected source order for contention is derived from the round-robin
// rule: after a packet from port p, the next grant goes to p+1.
module tb_pcap_stream_arbiter;

   localparam int NP = 2;
   localparam int DW = 64;
   localparam int KW = 8;
   localparam int CW = 8;
   localparam int SW = 1;

   logic             clk_out;
   logic             reset_n;
   logic [NP-1:0]    s_valid;
   logic [NP-1:0]    s_ready;
   logic [NP*DW-1:0] s_data;
   logic [NP*KW-1:0] s_keep;
   logic [NP-1:0]    s_last;
   logic             m_valid;
   logic             m_ready;
   logic [DW-1:0]    m_data;
   logic [KW-1:0]    m_keep;
   logic             m_last;
   logic [SW-1:0]    m_src;
   logic [NP*CW-1:0] pkt_cnt;
   logic             busy;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   beat_t src_q [NP][$];
   beat_t exp_q [NP][$];
   int    ord_q [$];
   int    cnt_model [NP];
   int    rr_model;
   int    cmp_cnt;
   int    err_cnt;
   bit    gap_en;
   bit    hold1;
   bit    rdy_rand;
   logic  rdy_force;

   pcap_stream_arbiter #(
      .NUM_PORTS (NP),
      .DATA_WIDTH(DW),
      .KEEP_WIDTH(KW),
      .CNT_WIDTH (CW),
      .SRC_WIDTH (SW)
   ) dut (
      .clk_out(clk_out),
      .reset_n(reset_n),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data (s_data),
      .s_keep (s_keep),
      .s_last (s_last),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .m_data (m_data),
      .m_keep (m_keep),
      .m_last (m_last),
      .m_src  (m_src),
      .pkt_cnt(pkt_cnt),
      .busy   (busy)
   );

   initial begin
      clk_out = 1'b0;
      forever #5 clk_out = ~clk_out;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at 1 ms, required to finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
      cmp_cnt++;
      if (got !== want) begin
         err_cnt++;
         $display("FAIL %s: got %0h required %0h", name, got, want);
      end
   endtask

   task automatic push_pkt(input int p, input int len, input logic [KW-1:0] last_keep);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data = {$urandom, $urandom};
         b.keep = (i == len - 1) ? last_keep : '1;
         b.last = (i == len - 1);
         src_q[p].push_back(b);
         exp_q[p].push_back(b);
      end
      cnt_model[p]++;
   endtask

   task automatic check_cnts(input string tag);
      for (int p = 0; p < NP; p++) begin
         check($sformatf("%s_pkt_cnt%0d", tag, p), pkt_cnt[p*CW +: CW], cnt_model[p] % 256);
      end
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while ((src_q[0].size() + src_q[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
             || m_valid) begin
         @(negedge clk_out);
         t++;
         if (t > 4000) break;
      end
      cmp_cnt++;
      if (t > 4000) begin
         err_cnt++;
         $display("FAIL drain_%s: %0d beats outstanding after 4000 cycles, required 0", tag,
                  exp_q[0].size() + exp_q[1].size());
      end
   endtask

   task automatic wait_out(input string tag, input int src);
      int t = 0;
      while (!(m_valid && (src < 0 || int'(m_src) == src)) && t < 200) begin
         @(negedge clk_out);
         t++;
      end
      cmp_cnt++;
      if (t >= 200) begin
         err_cnt++;
         $display("FAIL %s: no output beat within 200 cycles, required one", tag);
      end
   endtask

   // Source driver and m_ready generator. It updates #1 after each rising edge
   // and retires a beat when that beat was offered and ready at the previous falling edge.
   initial begin : driver
      logic [NP-1:0] acc;
      beat_t         b;
      s_valid = '0;
      s_data  = '0;
      s_keep  = '0;
      s_last  = '0;
      m_ready = 1'b1;
      forever begin
         @(negedge clk_out);
         acc = s_valid & s_ready;
         @(posedge clk_out);
         #1;
         for (int p = 0; p < NP; p++) begin
            if (acc[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
            if (src_q[p].size() > 0 && !(p == 1 && hold1) &&
                !(gap_en && $urandom_range(0, 3) == 0)) begin
               b = src_q[p][0];
               s_valid[p]            = 1'b1;
               s_data[p*DW +: DW]    = b.data;
               s_keep[p*KW +: KW]    = b.keep;
               s_last[p]             = b.last;
            end else begin
               s_valid[p]            = 1'b0;
               s_data[p*DW +: DW]    = '0;
               s_keep[p*KW +: KW]    = '0;
               s_last[p]             = 1'b0;
            end
         end
         m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
      end
   end

   // Monitor: scoreboard compare, no-interleave, round-robin order, stall hold
   initial begin : monitor
      logic          in_pkt;
      logic [SW-1:0] cur_src;
      logic          prev_stall;
      logic [DW-1:0] pd;
      logic [KW-1:0] pk;
      logic          pl;
      logic [SW-1:0] ps;
      beat_t         e;
      in_pkt     = 1'b0;
      cur_src    = '0;
      prev_stall = 1'b0;
      forever begin
         @(negedge clk_out);
         if (!reset_n) begin
            in_pkt     = 1'b0;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("hold_data", m_data, pd);
               check("hold_ctl", {m_valid, m_keep, m_last, m_src}, {1'b1, pk, pl, ps});
            end
            if (m_valid && !m_ready) check("stall_s_ready", s_ready, '0);
            if (m_valid && m_ready) begin
               if (exp_q[m_src].size() == 0) begin
                  cmp_cnt++;
                  err_cnt++;
                  $display("FAIL extra_beat: got beat %0h from port %0d, required none", m_data,
                           m_src);
               end else begin
                  e = exp_q[m_src].pop_front();
                  check("beat", {m_data, m_keep, m_last}, e);
               end
               if (in_pkt) check("no_interleave", m_src, cur_src);
               else if (ord_q.size() > 0) check("rr_order", m_src, ord_q.pop_front());
               in_pkt  = !m_last;
               cur_src = m_src;
               if (m_last) rr_model = (int'(m_src) + 1) % NP;
            end
            prev_stall = m_valid && !m_ready;
            pd = m_data;
            pk = m_keep;
            pl = m_last;
            ps = m_src;
         end
      end
   end

   initial begin : main
      int            t;
      int            n;
      logic [KW-1:0] lk;
      logic          lb;
      logic [SW-1:0] ls;
      cmp_cnt   = 0;
      err_cnt   = 0;
      gap_en    = 1'b0;
      hold1     = 1'b0;
      rdy_rand  = 1'b0;
      rdy_force = 1'b1;
      rr_model  = 0;
      for (int p = 0; p < NP; p++) cnt_model[p] = 0;

      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #2;
      check("rst_ctl", {m_valid, m_last, m_src, busy, s_ready, m_keep}, '0);
      check("rst_data", m_data, '0);
      check_cnts("rst");
      repeat (2) @(posedge clk_out);
      #3 reset_n = 1'b1;

      // Single 3-beat packet from port 0
      @(negedge clk_out);
      push_pkt(0, 3, 8'h0F);
      t = 0;
      while (!s_valid[0] && t < 20) begin
         @(negedge clk_out);
         t++;
      end
      @(negedge clk_out);
      check("grant", {busy, s_ready, m_valid}, {1'b1, 2'b01, 1'b0});
      @(negedge clk_out);
      check("first_beat", m_valid, 1'b1);
      n  = 0;
      lk = '0;
      lb = 1'b1;
      ls = 1'b1;
      while (m_valid && n < 10) begin
         n++;
         if (m_last) begin
            lk = m_keep;
            lb = busy;
            ls = m_src;
         end
         @(negedge clk_out);
      end
      check("burst_len", n, 3);
      check("last_beat", {lk, lb, ls}, {8'h0F, 1'b0, 1'b0});
      drain("single");
      check_cnts("single");

      // Contention: both ports saturate with 2-beat packets
      @(negedge clk_out);
      for (int k = 0; k < 8; k++) ord_q.push_back((rr_model + k) % NP);
      for (int k = 0; k < 4; k++) begin
         push_pkt(0, 2, '1);
         push_pkt(1, 2, '1);
      end
      drain("contention");
      check("ord_consumed", ord_q.size(), 0);
      check_cnts("contention");

      // Output backpressure for 5 cycles mid-packet
      @(negedge clk_out);
      push_pkt(0, 4, 8'h3C);
      wait_out("bp_start", 0);
      rdy_force = 1'b0;
      repeat (6) @(posedge clk_out);
      rdy_force = 1'b1;
      drain("backpressure");
      check_cnts("backpressure");

      // Port 1 stalls mid-packet while port 0 waits
      @(negedge clk_out);
      ord_q.push_back(1);
      ord_q.push_back(0);
      push_pkt(1, 4, 8'h01);
      wait_out("stall_start", 1);
      hold1 = 1'b1;
      push_pkt(0, 2, 8'hF0);
      @(negedge clk_out);
      repeat (4) begin
         @(negedge clk_out);
         check("src_stall", {busy, s_ready[0]}, {1'b1, 1'b0});
      end
      hold1 = 1'b0;
      drain("src_stall");
      check_cnts("src_stall");

      // Asynchronous reset while beat 2 sits in the output register
      @(negedge clk_out);
      push_pkt(0, 4, 8'hFF);
      wait_out("rst_start", 0);
      @(posedge clk_out);
      #3 reset_n = 1'b0;
      for (int p = 0; p < NP; p++) begin
         src_q[p].delete();
         exp_q[p].delete();
         cnt_model[p] = 0;
      end
      ord_q.delete();
      rr_model = 0;
      #1;
      check("arst_ctl", {m_valid, m_last, m_src, busy, s_ready, m_keep}, '0);
      check("arst_data", m_data, '0);
      check_cnts("arst");
      @(posedge clk_out);
      #3 reset_n = 1'b1;
      @(negedge clk_out);
      ord_q.push_back(1);
      push_pkt(1, 3, 8'h07);
      drain("post_reset");
      check_cnts("post_reset");

      // Counter wrap: 256 single-beat packets from port 0
      @(negedge clk_out);
      for (int k = 0; k < 256; k++) push_pkt(0, 1, 8'($urandom_range(1, 255)));
      drain("wrap");
      check("wrap_cnt0", pkt_cnt[CW-1:0], 8'd0);
      check_cnts("wrap");

      // Randomized traffic with source gaps and random m_ready
      gap_en   = 1'b1;
      rdy_rand = 1'b1;
      for (int r = 0; r < 2; r++) begin
         @(negedge clk_out);
         for (int k = 0; k < 30; k++) begin
            push_pkt($urandom_range(0, 1), $urandom_range(1, 6), 8'($urandom_range(1, 255)));
         end
         drain("random");
         repeat ($urandom_range(1, 5)) @(negedge clk_out);
      end
      rdy_rand = 1'b0;
      gap_en   = 1'b0;
      @(negedge clk_out);
      check_cnts("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
